// File: rtl/dff_mem_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing the single-port DFF scratch RAM.
// Supports a bounded lock burst and routes registered read data back to the issuing client.
module dff_mem_arbiter #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_lock,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_BITS-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_lock,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_BITS-1:0] b_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2
    } src_t;

    typedef struct packed {
        logic                 req;
        logic                 lock;
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } mem_req_t;

    mem_req_t      req_a, req_b, req_g;
    src_t          gsel;
    src_t          owner_q, owner_d;
    src_t          last_q, last_d;
    src_t          pend_q, pend_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          gnt_prev_q, gnt_prev_d;

    assign req_a = {a_req, a_lock, a_we, a_addr, a_wdata};
    assign req_b = {b_req, b_lock, b_we, b_addr, b_wdata};

    // Lock holds ownership unless the burst limit is hit while the other side waits.
    always_comb begin
        gsel = SRC_NONE;
        if (!rst) begin
            if (owner_q == SRC_A && req_a.req && (!req_b.req || burst_q < BURST_LIM))
                gsel = SRC_A;
            else if (owner_q == SRC_B && req_b.req && (!req_a.req || burst_q < BURST_LIM))
                gsel = SRC_B;
            else if (req_a.req && req_b.req)
                gsel = (last_q == SRC_A) ? SRC_B : SRC_A;
            else if (req_a.req)
                gsel = SRC_A;
            else if (req_b.req)
                gsel = SRC_B;
        end
    end

    always_comb begin
        req_g = '0;
        case (gsel)
            SRC_A:   req_g = req_a;
            SRC_B:   req_g = req_b;
            default: req_g = '0;
        endcase
    end

    assign a_gnt     = (gsel == SRC_A);
    assign b_gnt     = (gsel == SRC_B);
    assign mem_en    = req_g.req;
    assign mem_we    = req_g.we;
    assign mem_addr  = req_g.addr;
    assign mem_wdata = req_g.wdata;

    // burst_cnt counts repeat grants to the same client in back-to-back cycles.
    always_comb begin
        owner_d    = SRC_NONE;
        last_d     = last_q;
        burst_d    = '0;
        pend_d     = SRC_NONE;
        gnt_prev_d = 1'b0;
        if (gsel != SRC_NONE) begin
            last_d     = gsel;
            gnt_prev_d = 1'b1;
            if (gnt_prev_q && last_q == gsel)
                burst_d = (burst_q == '1) ? burst_q : burst_q + CW'(1);
            owner_d = req_g.lock ? gsel : SRC_NONE;
            pend_d  = req_g.we ? SRC_NONE : gsel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= SRC_NONE;
            last_q     <= SRC_B;
            burst_q    <= '0;
            pend_q     <= SRC_NONE;
            gnt_prev_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            pend_q     <= pend_d;
            gnt_prev_q <= gnt_prev_d;
        end
    end

    assign a_rvalid = (pend_q == SRC_A);
    assign b_rvalid = (pend_q == SRC_B);
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule

// File: doc/dff_mem_arbiter.md
Name: dff_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 16x8 DFF scratch RAM. The RAM has a registered read output.
- Grants one access per cycle using round-robin priority.
- Supports a bounded "lock" burst so one requester can keep consecutive accesses.
- Routes read data back to the requester that issued the read, with a valid strobe.
- Sits between the two client blocks and the RAM instance.

Parameters:
- ADDR_BITS, 4, RAM address width (16 entries).
- DATA_BITS, 8, RAM word width.
- MAX_BURST, 4, maximum consecutive locked grants to one requester while the other is requesting (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_req  input  1  requester A wants an access this cycle.
- a_lock  input  1  A requests to keep ownership for the following cycle.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  ADDR_BITS  A access address.
- a_wdata  input  DATA_BITS  A write data.
- a_gnt  output  1  A access accepted this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered).
- a_rdata  output  DATA_BITS  A read data.
- b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- mem_en  output  1  an access is issued to the RAM this cycle.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_BITS  RAM address.
- mem_wdata  output  DATA_BITS  RAM write data.
- mem_rdata  input  DATA_BITS  RAM registered read data; valid one cycle after the address is presented.

Behaviour:
- Handshake: a transfer occurs in a cycle where req && gnt. The requester holds addr/we/wdata stable while req=1 and gnt=0. Grant is combinational from req and registered state.
- At most one gnt per cycle.
- mem_en = a_gnt|b_gnt.
- mem_addr, mem_we and mem_wdata are muxed from the granted requester, same cycle. When there is no grant, mem_we=0 and mem_addr/mem_wdata=0.
- Registered state:
  - owner {NONE,A,B}
  - last_winner {A,B}
  - burst_cnt, $clog2(MAX_BURST)+1 bits
  - rd_pend {none,A,B}
- Arbitration, in priority order:
  - (1) Lock rule: owner==X and X_req → grant X. This applies if the other requester is idle, or if burst_cnt < MAX_BURST-1.
  - (2) Both requesting → grant the requester != last_winner.
  - (3) Otherwise → grant the single requester.
  - (4) No requests → no grant.
- State update on each grant to X:
  - last_winner <= X.
  - burst_cnt <= (X==previous grantee in the preceding cycle) ? sat_inc(burst_cnt) : 0.
  - owner <= X_lock ? X : NONE.
- No grant this cycle: owner <= NONE and burst_cnt <= 0.
- Burst limit: when the limit forces a switch, owner and burst_cnt follow the normal update for the new grantee. The preempted requester simply waits.
- Read return:
  - A granted read (we=0) sets rd_pend <= grantee. Otherwise rd_pend <= none.
  - X_rvalid = (rd_pend==X), registered, so it asserts exactly 1 cycle after the read grant.
  - a_rdata = b_rdata = mem_rdata (pass-through), meaningful only with rvalid.
- Back-to-back reads to alternating requesters: each returns on the following cycle with no bubble.
- Write then read, same address, consecutive cycles: the read returns the new data.
- Same-cycle write+read conflict is impossible; accesses are single-port and serialized.
- Reset values:
  - owner=NONE, last_winner=B (A wins the first tie), burst_cnt=0, rd_pend=none.
  - a_rvalid=b_rvalid=0.
  - While rst=1: a_gnt=b_gnt=0, mem_en=0, mem_we=0.
- Reset mid-operation: a pending read is dropped; no rvalid appears after reset deasserts.
- Locks held without req are ignored.
- lock on a write is allowed; lock on a mixed read/write burst is allowed.

Test Plan:
- Reset, then a_req=1 read addr 3 → a_gnt=1 in the same cycle, mem_en=1, mem_addr=3, mem_we=0. Next cycle a_rvalid=1 and a_rdata equals the mem_rdata model value; b_rvalid stays 0.
- a_req and b_req held continuously, no locks → grants alternate A,B,A,B starting with A after reset. Each gets exactly 1 grant per 2 cycles.
- A writes 0x5A to addr 7 (granted), B reads addr 7 the next cycle → b_rvalid one cycle later with b_rdata=0x5A.
- MAX_BURST=4: a_req+a_lock held, b_req held → A granted 4 consecutive cycles, then B once, then A again. With b_req=0, A is granted indefinitely.
- A read granted in cycle N, rst pulsed asynchronously before edge N+1 → a_rvalid=0 through and after reset, gnt=0 during reset, last_winner=B afterwards (A wins the next tie).
- No req for 5 cycles → mem_en=0, mem_we=0, both gnt=0, owner released. A new b_req alone is granted immediately.
